// File: rtl/video_timing_pkg.sv
// Shared constants for the raster timing generator: default 720p60 timing, sync polarities,
// lock-qualifier state encoding and the colour-bar lookup.
package video_timing_pkg;

    localparam int unsigned DefHActive    = 1280;
    localparam int unsigned DefHFp        = 110;
    localparam int unsigned DefHSync      = 40;
    localparam int unsigned DefHBp        = 220;
    localparam int unsigned DefVActive    = 720;
    localparam int unsigned DefVFp        = 5;
    localparam int unsigned DefVSync      = 5;
    localparam int unsigned DefVBp        = 20;
    localparam int unsigned DefLockStable = 1024;

    localparam logic DefHsPol = 1'b1;
    localparam logic DefVsPol = 1'b1;

    typedef enum logic [1:0] {
        StWaitLock,
        StStabilize,
        StRun
    } lock_state_e;

    // Bar 0 is leftmost: white, yellow, cyan, green, magenta, red, blue, black.
    function automatic logic [23:0] colour_bar(input logic [2:0] idx);
        logic [23:0] rgb;
        rgb = 24'h000000;
        unique case (idx)
            3'd0: rgb = 24'hFFFFFF;
            3'd1: rgb = 24'hFFFF00;
            3'd2: rgb = 24'h00FFFF;
            3'd3: rgb = 24'h00FF00;
            3'd4: rgb = 24'hFF00FF;
            3'd5: rgb = 24'hFF0000;
            3'd6: rgb = 24'h0000FF;
            3'd7: rgb = 24'h000000;
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/video_timing_gen_lock_qualifier.sv
// PLL lock qualifier: 2-flop synchroniser, stability counter and WAIT_LOCK/STABILIZE/RUN FSM.
// run_o is high only after LOCK_STABLE consecutive synchronised lock-high cycles.
module video_timing_gen_lock_qualifier
    import video_timing_pkg::*;
#(
    parameter int unsigned LOCK_STABLE = DefLockStable
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pll_lock_i,
    output logic run_o
);

    localparam int unsigned SW = (LOCK_STABLE > 2) ? $clog2(LOCK_STABLE) : 1;
    localparam logic [SW-1:0] StabLast = SW'(LOCK_STABLE - 1);

    logic        lk_meta_q;
    logic        lk_q;
    lock_state_e state_q;
    logic [SW-1:0] stab_cnt_q;
    logic        run_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lk_meta_q <= 1'b0;
            lk_q      <= 1'b0;
        end else begin
            lk_meta_q <= pll_lock_i;
            lk_q      <= lk_meta_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StWaitLock;
            stab_cnt_q <= '0;
            run_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StWaitLock: begin
                    stab_cnt_q <= '0;
                    run_q      <= 1'b0;
                    if (lk_q) begin
                        state_q <= StStabilize;
                    end
                end
                StStabilize: begin
                    if (!lk_q) begin
                        state_q    <= StWaitLock;
                        stab_cnt_q <= '0;
                    end else if (stab_cnt_q == StabLast) begin
                        state_q <= StRun;
                        run_q   <= 1'b1;
                    end else begin
                        stab_cnt_q <= stab_cnt_q + SW'(1);
                    end
                end
                StRun: begin
                    if (!lk_q) begin
                        state_q    <= StWaitLock;
                        stab_cnt_q <= '0;
                        run_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= StWaitLock;
                    stab_cnt_q <= '0;
                    run_q      <= 1'b0;
                end
            endcase
        end
    end

    assign run_o = run_q;

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: h/v counters plus registered hs/vs/de, coordinates and strobes.
// Optional colour-bar pattern on rgb_o when VIDEO_TIMING_PATTERN_EN is defined.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = DefHActive,
    parameter int unsigned H_FP        = DefHFp,
    parameter int unsigned H_SYNC      = DefHSync,
    parameter int unsigned H_BP        = DefHBp,
    parameter int unsigned V_ACTIVE    = DefVActive,
    parameter int unsigned V_FP        = DefVFp,
    parameter int unsigned V_SYNC      = DefVSync,
    parameter int unsigned V_BP        = DefVBp,
    parameter logic        HS_POL      = DefHsPol,
    parameter logic        VS_POL      = DefVsPol,
    parameter int unsigned LOCK_STABLE = DefLockStable,
    localparam int unsigned H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int unsigned V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int unsigned XW         = $clog2(H_TOTAL),
    localparam int unsigned YW         = $clog2(V_TOTAL)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          pll_lock_i,
    output logic          timing_valid_o,
    output logic          hs_o,
    output logic          vs_o,
    output logic          de_o,
    output logic [XW-1:0] x_o,
    output logic [YW-1:0] y_o,
    output logic          line_start_o,
`ifdef VIDEO_TIMING_PATTERN_EN
    output logic [23:0]   rgb_o,
`endif
    output logic          frame_start_o
);

    localparam logic [XW-1:0] HActive = XW'(H_ACTIVE);
    localparam logic [XW-1:0] HsStart = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] HsEnd   = XW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [XW-1:0] HLast   = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] VActive = YW'(V_ACTIVE);
    localparam logic [YW-1:0] VsStart = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] VsEnd   = YW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [YW-1:0] VLast   = YW'(V_TOTAL - 1);

    logic          run;
    logic [XW-1:0] h_q, h_d;
    logic [YW-1:0] v_q, v_d;
    logic          de_d, hs_d, vs_d, ls_d, fs_d;

    video_timing_gen_lock_qualifier #(
        .LOCK_STABLE (LOCK_STABLE)
    ) u_lock_qualifier (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .pll_lock_i (pll_lock_i),
        .run_o      (run)
    );

    // Counters sit at (0,0) outside RUN so every restart begins a fresh frame.
    always_comb begin
        h_d = '0;
        v_d = '0;
        if (run) begin
            if (h_q == HLast) begin
                h_d = '0;
                v_d = (v_q == VLast) ? '0 : v_q + YW'(1);
            end else begin
                h_d = h_q + XW'(1);
                v_d = v_q;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    always_comb begin
        de_d = run && (h_q < HActive) && (v_q < VActive);
        hs_d = ~HS_POL;
        vs_d = ~VS_POL;
        if (run && (h_q >= HsStart) && (h_q < HsEnd)) begin
            hs_d = HS_POL;
        end
        if (run && (v_q >= VsStart) && (v_q < VsEnd)) begin
            vs_d = VS_POL;
        end
        ls_d = run && (h_q == '0);
        fs_d = run && (h_q == '0) && (v_q == '0);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            timing_valid_o <= 1'b0;
            hs_o           <= ~HS_POL;
            vs_o           <= ~VS_POL;
            de_o           <= 1'b0;
            x_o            <= '0;
            y_o            <= '0;
            line_start_o   <= 1'b0;
            frame_start_o  <= 1'b0;
        end else begin
            timing_valid_o <= run;
            hs_o           <= hs_d;
            vs_o           <= vs_d;
            de_o           <= de_d;
            x_o            <= run ? h_q : '0;
            y_o            <= run ? v_q : '0;
            line_start_o   <= ls_d;
            frame_start_o  <= fs_d;
        end
    end

`ifdef VIDEO_TIMING_PATTERN_EN
    localparam logic [XW-1:0] BarW = XW'(H_ACTIVE / 8);

    logic [XW-1:0] bar_raw;
    logic [2:0]    bar_idx;
    logic [23:0]   rgb_d;

    always_comb begin
        bar_raw = h_q / BarW;
        bar_idx = (bar_raw > XW'(7)) ? 3'd7 : bar_raw[2:0];
        rgb_d   = de_d ? colour_bar(bar_idx) : 24'h000000;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rgb_o <= '0;
        end else begin
            rgb_o <= rgb_d;
        end
    end
`endif

endmodule
